// File: rtl/elab_pkg.sv
// rtl/elab_pkg.sv - shared state type and default sizes for ram_scan
package elab_pkg;

  localparam int WORD_NUM_DEF = 16;
  localparam int DATA_W_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } scan_state_e;

endpackage

// File: rtl/ram_scan.sv
// rtl/ram_scan.sv - paced RAM read-back scanner comparing each word to an address+SEED pattern
module ram_scan
  import elab_pkg::*;
#(
  parameter int WORD_NUM = WORD_NUM_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEED     = 0,
  localparam int ADDR_W  = $clog2(WORD_NUM),
  localparam int ERR_W   = $clog2(WORD_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ena,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_q,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              fail
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_NUM - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(WORD_NUM);
  localparam logic [DATA_W-1:0] SEED_W    = DATA_W'(SEED);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] exp_word;

  // Truncating the address before the add gives the mod 2^DATA_W wrap for free.
  assign exp_word = DATA_W'(rd_addr_q) + SEED_W;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          rd_addr_d = '0;
          err_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (ena) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        data_d  = rd_q;
        valid_d = 1'b1;
        if ((rd_q != exp_word) && (err_cnt_q != ERR_MAX)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        if (rd_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign err_cnt = err_cnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign fail    = (err_cnt_q != '0);

endmodule
